// File: rtl/seq_match_fsm_pkg.sv
// Shared types and helpers for the programmable sequence matcher.
// Used by seq_match_fsm and seq_match_fsm_step_timer.
package seq_match_fsm_pkg;

  typedef enum logic [1:0] {
    SEQ_IDLE  = 2'd0,
    SEQ_STEP  = 2'd1,
    SEQ_DONE  = 2'd2,
    SEQ_FAULT = 2'd3
  } seq_state_t;

  // Fill bits for the fixed Q codes; replicate to any QW with {QW{...}}
  localparam logic Q_IDLE = 1'b0;
  localparam logic Q_DONE = 1'b1;

  // Width of step_idx: must hold 0..STEPS
  function automatic int idx_w(input int steps);
    return (steps < 1) ? 1 : $clog2(steps + 1);
  endfunction

  // Width of the step timer: must hold 0..TIMEOUT (at least one bit)
  function automatic int timer_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/seq_match_fsm_step_timer.sv
// Per-step dwell timer. Counts cycles while en is high, restarts on clr,
// and flags expired on the last permitted cycle (count == TIMEOUT-1).
// The count saturates at TIMEOUT. TIMEOUT=0 removes the counter entirely.
module seq_match_fsm_step_timer
  import seq_match_fsm_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rstN,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = timer_w(TIMEOUT);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rstN, clr, en};
      assign expired       = 1'b0;
    end else begin : g_on
      logic [TW-1:0] timer;

      // Count non-advancing cycles in the current step, holding at TIMEOUT
      always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
          timer <= '0;
        end else if (clr) begin
          timer <= '0;
        end else if (en && (timer != TW'(TIMEOUT))) begin
          timer <= timer + TW'(1);
        end
      end

      assign expired = (timer == TW'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/seq_match_fsm.sv
// Programmable Moore sequence matcher: walks STEPS value/mask match steps,
// driving a per-step Q code, with per-step timeout, FAULT, abort and
// done/busy status. Outputs decode from registered state only.
// Optional completed-sequence counter: define SEQ_MATCH_HIT_COUNT_EN.
module seq_match_fsm
  import seq_match_fsm_pkg::*;
#(
  parameter int DW      = 4,
  parameter int STEPS   = 4,
  parameter int QW      = 3,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic                       abort,
  input  logic                       clear,
  input  logic                       din_valid,
  input  logic [DW-1:0]              din,
  input  logic [STEPS*DW-1:0]        match_val,
  input  logic [STEPS*DW-1:0]        match_mask,
  input  logic [STEPS*QW-1:0]        step_q,
  input  logic [QW-1:0]              fault_q,
  output logic [QW-1:0]              Q,
  output logic [$clog2(STEPS+1)-1:0] step_idx,
  output logic                       busy,
  output logic                       done,
  output logic                       timeout,
  output logic [15:0]                hit_count
);

  localparam int            IW   = idx_w(STEPS);
  localparam logic [IW-1:0] LAST = IW'(STEPS - 1);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [IW-1:0] idx_nxt;
  logic [DW-1:0] cur_val;
  logic [DW-1:0] cur_mask;
  logic [QW-1:0] cur_q;
  logic          hit;
  logic          expired;
  logic          tmr_clr;
  logic          tmr_en;

  // Pick the live compare value, mask and Q code of the current step
  always_comb begin
    cur_val  = '0;
    cur_mask = '0;
    cur_q    = '0;
    for (int k = 0; k < STEPS; k++) begin
      if (step_idx == IW'(k)) begin
        cur_val  = match_val[k*DW +: DW];
        cur_mask = match_mask[k*DW +: DW];
        cur_q    = step_q[k*QW +: QW];
      end
    end
  end

  assign hit = din_valid && (((din ^ cur_val) & cur_mask) == '0);

  // Timer runs only while waiting in a step; any advance or exit restarts it
  assign tmr_clr = (state != SEQ_STEP) || hit;
  assign tmr_en  = (state == SEQ_STEP) && !hit;

  seq_match_fsm_step_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rstN    (rstN),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  // State and step index register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= SEQ_IDLE;
      step_idx <= '0;
    end else begin
      state    <= state_nxt;
      step_idx <= idx_nxt;
    end
  end

  // Next state: abort > clear > hit > timeout expiry
  always_comb begin
    state_nxt = state;
    idx_nxt   = step_idx;
    case (state)
      SEQ_IDLE: begin
        if (start) begin
          state_nxt = SEQ_STEP;
          idx_nxt   = '0;
        end
      end
      SEQ_STEP: begin
        if (abort) begin
          state_nxt = SEQ_IDLE;
          idx_nxt   = '0;
        end else if (hit) begin
          if (step_idx == LAST) begin
            state_nxt = SEQ_DONE;
          end else begin
            idx_nxt = step_idx + IW'(1);
          end
        end else if (expired) begin
          state_nxt = SEQ_FAULT;
        end
      end
      SEQ_DONE: begin
        state_nxt = SEQ_IDLE;
        idx_nxt   = '0;
      end
      SEQ_FAULT: begin
        if (abort || clear) begin
          state_nxt = SEQ_IDLE;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = SEQ_IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    Q       = {QW{Q_IDLE}};
    busy    = 1'b0;
    done    = 1'b0;
    timeout = 1'b0;
    case (state)
      SEQ_STEP: begin
        Q    = cur_q;
        busy = 1'b1;
      end
      SEQ_DONE: begin
        Q    = {QW{Q_DONE}};
        done = 1'b1;
      end
      SEQ_FAULT: begin
        Q       = fault_q;
        timeout = 1'b1;
      end
      default: begin
        Q = {QW{Q_IDLE}};
      end
    endcase
  end

`ifdef SEQ_MATCH_HIT_COUNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] hit_cnt;

  // Count completed sequences, holding at the maximum; only reset clears it
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hit_cnt <= '0;
    end else if (state == SEQ_DONE) begin
      hit_cnt <= sat_inc16(hit_cnt);
    end
  end

  assign hit_count = hit_cnt;
`else
  assign hit_count = 16'h0000;
`endif

endmodule

// File: doc/seq_match_fsm.md
Name: seq_match_fsm

Overview:
- Parametrised successor to the fixed-sequence Moore controllers in chapter 3.
- Walks a programmable sequence of STEPS data-match conditions, each with a value and a mask, and drives a per-step Moore output code Q.
- Adds a per-step timeout, a fault state, abort, and done/busy status.
- Sits between an input sampler and downstream actuators in the example designs.

Parameters:
DW, 4, width of compared data word din
STEPS, 4, number of sequence steps (>=1)
QW, 3, width of Moore output code Q
TIMEOUT, 15, max cycles spent in one step before fault; 0 disables timeout

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
start  input  1  launch sequence from IDLE
abort  input  1  return to IDLE from any state
clear  input  1  leave FAULT to IDLE
din_valid  input  1  din qualifier
din  input  DW  data word compared at current step
match_val  input  STEPS*DW  step k expected value at [k*DW +: DW]
match_mask  input  STEPS*DW  step k compare mask; 1 = bit compared
step_q  input  STEPS*QW  Q code for step k at [k*QW +: QW]
fault_q  input  QW  Q code while in FAULT
Q  output  QW  Moore output code
step_idx  output  $clog2(STEPS+1)  current step index
busy  output  1  high in STEP
done  output  1  one-cycle pulse in DONE
timeout  output  1  high in FAULT
hit_count  output  16  completed-sequence count (optional feature)

Behaviour:
- Reset is asynchronous and active-low (rstN). One clock (clk). On reset: state=IDLE, step_idx=0, timer=0, Q=0, busy=0, done=0, timeout=0, hit_count=0.
- Q, busy, done and timeout decode combinationally from registered state only, with no input-to-output path.
- IDLE: Q=0. start=1 -> STEP with step_idx=0 and timer=0.
- STEP k: Q=step_q[k]. A hit is din_valid && ((din ^ match_val[k]) & match_mask[k]) == 0.
  - hit with k<STEPS-1 -> step_idx=k+1, timer=0.
  - hit with k=STEPS-1 -> DONE.
  - no hit -> timer+1; when timer==TIMEOUT-1 and no hit -> FAULT.
- DONE: Q = all ones, done=1 for exactly one cycle, then IDLE with step_idx=0.
- FAULT: Q=fault_q, timeout=1, step_idx holds the failing step. clear=1 -> IDLE. Otherwise FAULT holds.
- Latency: a hit sampled at edge n changes Q after edge n. Minimum start-to-done is STEPS+1 edges.
- Priority per cycle: abort > clear > hit > timeout expiry. A hit on the expiry cycle advances.
- start is ignored outside IDLE. abort in IDLE is a no-op.
- match_mask[k]=0 means any valid word matches step k.
- TIMEOUT=0: the timer never expires and FAULT is unreachable.
- match_val, match_mask, step_q and fault_q must be stable outside IDLE. They are compared live, not captured.
- Timer width is $clog2(TIMEOUT+1) and saturates. It does not wrap.
- rstN asserted mid-sequence returns to IDLE immediately, asynchronously.

Optional Feature:
- SEQ_MATCH_HIT_COUNT_EN defined: hit_count increments on each DONE cycle, saturates at 16'hFFFF, and is cleared only by rstN.
- Undefined: the counter logic is omitted and hit_count is tied to 16'h0000. The port list is identical either way.

Decomposition:
- Package common:
  - typedef enum logic [1:0] seq_state_t {SEQ_IDLE, SEQ_STEP, SEQ_DONE, SEQ_FAULT}.
  - Localparam helpers for index width.
  - Q_IDLE = '0 and Q_DONE = '1 constants, width-agnostic fills.
- Sub-module step_timer:
  - Parameter TIMEOUT; inputs clk, rstN, clr, en; output expired.
  - Instantiated once.
  - When TIMEOUT=0, expired is tied to 0.

Test Plan (DW=4, STEPS=4, QW=3, TIMEOUT=8; match_val 1,4,8,2; masks F; step_q 001,011,100,110; fault_q 101):
- Full sequence: start, then valid din 1,4,8,2 on consecutive cycles -> Q steps 001,011,100,110, then 111 with done=1 for one cycle, then Q=000; hit_count=1 with feature on.
- Gaps and mismatches: in step 1 drive din 3 valid, then 4 with din_valid=0, then 4 valid -> stays at step_idx 1 until the third cycle, then advances.
- Timeout: start, then no valid input -> after 8 cycles timeout=1, Q=101, step_idx=0; clear -> IDLE, Q=000.
- Match on expiry cycle: din=1 valid on cycle 8 of step 0 -> advances to step 1; no FAULT.
- Priority: abort and a valid hit together in step 2 -> IDLE, Q=000, step_idx=0; start while in STEP is ignored.
- Mask and reset: mask[3]=0 -> any valid word completes step 3; rstN low mid-step 2 -> Q=000 and step_idx=0 asynchronously.
